output_port_arbiter: RTL and testbench

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

---
 rtl/output_port_arbiter.sv | 75 +++++++
 tb/tb_output_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter for N input buffers that share
// one output port. Flits move only while the downstream buffer has credits.
module output_port_arbiter #(
    parameter int N = 4,
    parameter int CREDITS = 8,
    localparam int SW = $clog2(N),
    localparam int CW = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  empty_i,
    input  logic [N-1:0]  tail_i,
    input  logic          credit_i,
    output logic [N-1:0]  read_o,
    output logic          write_o,
    output logic [SW-1:0] sel_o,
    output logic [CW-1:0] credits_o,
    output logic          busy_o,
    output logic          overflow_o
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t        state, state_n;
    logic [SW-1:0] grant, grant_n, rr_ptr, rr_ptr_n, pick;
    logic [CW-1:0] credits_n;
    logic [N-1:0]  req, req_hi;
    logic          has_credit, xfer, ovf_set;
    assign req = ~empty_i;
    assign req_hi = req & ~((N'(1) << rr_ptr) - N'(1));
    assign has_credit = credits_o != '0;
    // Requesters at or above rr_ptr win; otherwise wrap to the lowest requester.
    always_comb begin
        pick = rr_ptr;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) pick = SW'(i);
        for (int i = N - 1; i >= 0; i--)
            if (req_hi[i]) pick = SW'(i);
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        rr_ptr_n = rr_ptr;
        xfer = state == LOCKED && req[grant] && has_credit;
        if (state == IDLE && |req && has_credit) begin
            state_n = LOCKED;
            grant_n = pick;
        end
        if (xfer && tail_i[grant]) begin
            state_n = IDLE;
            rr_ptr_n = grant == SW'(N - 1) ? '0 : grant + SW'(1);
        end
    end
    assign read_o = xfer ? N'(1) << grant : '0;
    assign write_o = xfer;
    assign sel_o = grant;
    assign busy_o = state == LOCKED;
    // A returned credit that cannot be counted is a protocol error, kept sticky.
    assign ovf_set = credit_i && !write_o && credits_o == CW'(CREDITS);
    assign credits_n = write_o && !credit_i ? credits_o - CW'(1) :
                       credit_i && !write_o && !ovf_set ? credits_o + CW'(1) : credits_o;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= '0;
            credits_o <= CW'(CREDITS);
            overflow_o <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            rr_ptr <= rr_ptr_n;
            credits_o <= credits_n;
            overflow_o <= overflow_o | ovf_set;
        end
    end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed vector table, corner sequences and random traffic
// checked against a behavioural model of the arbiter.
module tb_output_port_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] empty_i = 4'hF;
    logic [3:0] tail_i = 4'h0;
    logic       credit_i = 1'b0;
    logic [3:0] read_o;
    logic       write_o;
    logic [1:0] sel_o;
    logic [3:0] credits_o;
    logic       busy_o;
    logic       overflow_o;

    int n_chk = 0;
    int n_fail = 0;

    int m_ptr, m_grant, m_cred;
    bit m_lock, m_ovf, m_write;

    output_port_arbiter #(.N(4), .CREDITS(8)) dut (
        .clk(clk), .rst(rst), .empty_i(empty_i), .tail_i(tail_i), .credit_i(credit_i),
        .read_o(read_o), .write_o(write_o), .sel_o(sel_o), .credits_o(credits_o),
        .busy_o(busy_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] e, t;
        logic       c;
        logic [3:0] rd;
        logic       wr;
        logic [1:0] sel;
        logic [3:0] cr;
        logic       busy, ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_ptr = 0; m_grant = 0; m_cred = 8; m_lock = 0; m_ovf = 0; m_write = 0;
    endfunction

    // Compares the DUT against the model for the inputs currently applied.
    task automatic m_check(input string tag);
        logic [3:0] er;
        er = 4'b0;
        if (m_lock && !empty_i[2'(m_grant)] && m_cred > 0) er = 4'(1) << m_grant;
        m_write = er != 4'b0;
        chk({tag, "_read"}, 32'(read_o), 32'(er));
        chk({tag, "_write"}, 32'(write_o), 32'(m_write));
        chk({tag, "_sel"}, 32'(sel_o), 32'(m_grant));
        chk({tag, "_credits"}, 32'(credits_o), 32'(m_cred));
        chk({tag, "_busy"}, 32'(busy_o), 32'(m_lock));
        chk({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
    endtask

    function automatic void m_step();
        bit found;
        if (!m_lock) begin
            if (empty_i != 4'hF && m_cred > 0) begin
                found = 0;
                for (int k = 0; k < 4; k++)
                    if (!found && !empty_i[2'((m_ptr + k) % 4)]) begin
                        m_grant = (m_ptr + k) % 4;
                        found = 1;
                    end
                m_lock = 1;
            end
        end else if (m_write && tail_i[2'(m_grant)]) begin
            m_lock = 0;
            m_ptr = (m_grant + 1) % 4;
        end
        if (m_write && !credit_i) m_cred--;
        else if (credit_i && !m_write) begin
            if (m_cred == 8) m_ovf = 1;
            else m_cred++;
        end
    endfunction

    // Called at posedge+1; leaves the bench at the next posedge+1.
    task automatic apply(input logic [3:0] e, input logic [3:0] t, input logic c, input string tag);
        empty_i = e; tail_i = t; credit_i = c;
        #1;
        m_check(tag);
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        empty_i = 4'h0; tail_i = 4'h0; credit_i = 1'b0;
        #1;
        chk("rst_read", 32'(read_o), 32'h0);
        chk("rst_write", 32'(write_o), 32'h0);
        m_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_read", 32'(read_o), 32'h0);
        chk("rst_credits", 32'(credits_o), 32'd8);
        rst = 1'b1;
        empty_i = 4'hF;
    endtask

    vec_t vt[15];
    int writes;
    int exp_sel[$];

    initial begin
        vt[0]  = '{4'b0101, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'd8, 0, 0};
        vt[1]  = '{4'b0101, 4'b0000, 0, 4'b0010, 1, 2'd1, 4'd8, 1, 0};
        vt[2]  = '{4'b0101, 4'b0000, 0, 4'b0010, 1, 2'd1, 4'd7, 1, 0};
        vt[3]  = '{4'b0101, 4'b0010, 0, 4'b0010, 1, 2'd1, 4'd6, 1, 0};
        vt[4]  = '{4'b0101, 4'b0000, 0, 4'b0000, 0, 2'd1, 4'd5, 0, 0};
        vt[5]  = '{4'b0101, 4'b0000, 0, 4'b1000, 1, 2'd3, 4'd5, 1, 0};
        vt[6]  = '{4'b0101, 4'b0000, 0, 4'b1000, 1, 2'd3, 4'd4, 1, 0};
        vt[7]  = '{4'b0101, 4'b1000, 0, 4'b1000, 1, 2'd3, 4'd3, 1, 0};
        vt[8]  = '{4'b1111, 4'b0000, 1, 4'b0000, 0, 2'd3, 4'd2, 0, 0};
        vt[9]  = '{4'b1111, 4'b0000, 1, 4'b0000, 0, 2'd3, 4'd3, 0, 0};
        vt[10] = '{4'b1111, 4'b0000, 1, 4'b0000, 0, 2'd3, 4'd4, 0, 0};
        vt[11] = '{4'b1110, 4'b0000, 0, 4'b0000, 0, 2'd3, 4'd5, 0, 0};
        vt[12] = '{4'b1110, 4'b0000, 1, 4'b0001, 1, 2'd0, 4'd5, 1, 0};
        vt[13] = '{4'b1110, 4'b0001, 0, 4'b0001, 1, 2'd0, 4'd5, 1, 0};
        vt[14] = '{4'b1111, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'd4, 0, 0};

        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 10; i++) apply(4'hF, 4'h0, 1'b0, "idle");
        chk("idle_busy", 32'(busy_o), 32'h0);
        chk("idle_read", 32'(read_o), 32'h0);
        chk("idle_credits", 32'(credits_o), 32'd8);
        chk("idle_sel", 32'(sel_o), 32'h0);

        // Directed vector table.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            empty_i = vt[i].e; tail_i = vt[i].t; credit_i = vt[i].c;
            #1;
            chk($sformatf("vec%0d_out", i),
                {read_o, 3'b0, write_o, 2'b0, sel_o, credits_o, 3'b0, busy_o, 3'b0, overflow_o},
                {vt[i].rd, 3'b0, vt[i].wr, 2'b0, vt[i].sel, vt[i].cr, 3'b0, vt[i].busy, 3'b0, vt[i].ovf});
            m_check("vec");
            m_step();
            @(posedge clk);
            #1;
        end

        // Credit exhaustion on a never-ending packet, then one returned credit.
        do_reset();
        for (int i = 0; i < 9; i++) apply(4'b1011, 4'h0, 1'b0, "drain");
        empty_i = 4'b1011;
        #1;
        chk("drain_credits", 32'(credits_o), 32'h0);
        chk("drain_read", 32'(read_o), 32'h0);
        chk("drain_busy", 32'(busy_o), 32'h1);
        #1;
        writes = 0;
        for (int i = 0; i < 5; i++) begin
            empty_i = 4'b1011; credit_i = (i == 0);
            #1;
            writes += int'(write_o);
            m_check("oneshot");
            m_step();
            @(posedge clk);
            #1;
        end
        chk("oneshot_writes", 32'(writes), 32'd1);

        // Credit return while full sets the sticky overflow flag.
        do_reset();
        apply(4'hF, 4'h0, 1'b1, "ovf");
        for (int i = 0; i < 4; i++) apply(4'hF, 4'h0, 1'b0, "ovf_hold");
        chk("ovf_sticky", 32'(overflow_o), 32'h1);
        chk("ovf_credits", 32'(credits_o), 32'd8);
        do_reset();
        #1;
        chk("ovf_cleared", 32'(overflow_o), 32'h0);
        #1;

        // Round-robin rotation with single-flit packets on all inputs.
        do_reset();
        exp_sel = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 10; i++) begin
            empty_i = 4'h0; tail_i = 4'hF; credit_i = 1'b1;
            #1;
            chk("rr_write_phase", 32'(write_o), 32'(i % 2));
            if (write_o) chk("rr_sel", 32'(sel_o), 32'(exp_sel.pop_front()));
            m_check("rr");
            m_step();
            @(posedge clk);
            #1;
        end
        chk("rr_all_grants", 32'(exp_sel.size()), 32'd0);

        // Reset asserted during the second flit of a packet.
        do_reset();
        apply(4'b1110, 4'h0, 1'b0, "midrst");
        apply(4'b1110, 4'h0, 1'b0, "midrst");
        empty_i = 4'b1110;
        #1;
        chk("midrst_before", 32'(read_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst_read", 32'(read_o), 32'h0);
        chk("midrst_write", 32'(write_o), 32'h0);
        chk("midrst_credits", 32'(credits_o), 32'd8);
        chk("midrst_busy", 32'(busy_o), 32'h0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("midrst_sel", 32'(sel_o), 32'h0);
        for (int i = 0; i < 4; i++) apply(4'b1110, 4'(i == 3), 1'b0, "after_rst");

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++)
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 99) < 40), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
